apb_cmd_sequencer: RTL
======================

APB_CMD_SEQUENCER -- requirements
Module: apb_cmd_sequencer

Interface
REQ-001 Parameters (name, default, meaning):
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- CMD_DEPTH, 4, command queue entries (power of 2, >=2).
- RSP_DEPTH, 4, response queue entries (power of 2, >=2).

REQ-002 Ports (name, direction, width, meaning), one clock; reset is asynchronous and active-low:
- pclk  in  1  clock.
- presetn  in  1  reset.
- cmd_valid  in  1  host command present.
- cmd_ready  out  1  command queue can accept.
- cmd_addr  in  ADDR_WIDTH  command address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_write  in  1  1=write, 0=read.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  host pops response.
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes).
- rsp_error  out  1  transfer ended in error.
- rsp_write  out  1  echo of the command's cmd_write.
- transfer_req  out  1  one-cycle start strobe to the APB system.
- transfer_addr  out  ADDR_WIDTH  held from the strobe until completion.
- transfer_wdata  out  DATA_WIDTH  held from the strobe until completion.
- transfer_write  out  1  held from the strobe until completion.
- transfer_ready  in  1  completion strobe; rdata/error are valid in the same cycle.
- transfer_rdata  in  DATA_WIDTH  read data.
- transfer_error  in  1  error flag.
- busy  out  1  high when state is not IDLE or the command queue is non-empty.

Function
REQ-003 Command queue: FIFO of {addr, wdata, write}.
- cmd_ready = not full.
- A push occurs on a pclk edge where cmd_valid & cmd_ready.

REQ-004 Response queue: FIFO of {rdata, error, write}.
- rsp_valid = not empty; the head is shown on rsp_*.
- A pop occurs on an edge where rsp_valid & rsp_ready.

REQ-005 Issuer FSM states: IDLE, REQ, WAIT.

REQ-006 IDLE -> REQ when the command queue is non-empty and (response queue count + 0 outstanding) < RSP_DEPTH.
- On that edge: pop the command and load the transfer_* registers.

REQ-007 REQ:
- transfer_req = 1 for exactly this one cycle.
- Next state is WAIT unconditionally.

REQ-008 WAIT: on an edge with transfer_ready = 1:
- Push {write ? 0 : transfer_rdata, transfer_error, transfer_write} into the response queue.
- Go to IDLE.

REQ-009 transfer_ready is ignored in IDLE and REQ.

REQ-010 transfer_addr, transfer_wdata and transfer_write change only on the IDLE->REQ edge.

REQ-011 Latency:
- Command accepted at edge N with the queue empty and FSM in IDLE -> transfer_req high in the cycle after edge N+1.
- Response visible the cycle after the transfer_ready edge.
- Back-to-back: the next transfer_req follows 2 cycles after transfer_ready (one IDLE cycle).

REQ-012 Simultaneous push and pop on either queue at the same edge: count unchanged, data order preserved.

REQ-013 Response-space reservation: a command is never issued unless its response slot is guaranteed, so a push to a full response queue never occurs.

REQ-014 Ordering: responses are produced in strict command order; at most one transfer is outstanding.

REQ-015 FIFO pointers wrap modulo depth; full and empty are distinguished by an extra pointer bit.

Reset
REQ-016 While presetn = 0:
- FSM in IDLE, both queues empty.
- cmd_ready = 0.
- rsp_valid, rsp_rdata, rsp_error, rsp_write, transfer_req, transfer_addr, transfer_wdata, transfer_write, busy all = 0.

REQ-017 cmd_ready = 1 from the first cycle after reset release.

REQ-018 Reset mid-operation discards the in-flight transfer and all queued commands and responses; no response is produced for them.

Structure
REQ-019 Shared package apb_seq_pkg holds:
- the FSM state enum (IDLE, REQ, WAIT);
- default width and depth constants.

REQ-020 One sub-module, sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count), instantiated twice (command queue, response queue).

Verification
REQ-021 Write 0x00000008 / 0xDEADBEEF, then read 0x00000008 -> responses: {write=1, rdata=0, error=0}, then {write=0, rdata=0xDEADBEEF, error=0}, in order.

REQ-022 Read 0xFF000000 with transfer_error=1 at completion -> rsp_error=1, rsp_rdata=0x00000000.

REQ-023 transfer_ready held low, 6 commands offered -> 5 accepted (4 queued + 1 in WAIT), cmd_ready=0; releasing transfer_ready restores cmd_ready.

REQ-024 rsp_ready=0, 6 commands queued -> exactly 4 transfer_req strobes; one rsp pop -> the 5th transfer_req follows.

REQ-025 presetn asserted in WAIT with 2 commands queued -> all outputs 0 immediately; after release there are no transfer_req and no responses.

REQ-026 Back-to-back: 4 writes to 0x00000010..0x0000001C with 0-wait completion -> transfer_req pulses spaced exactly 3 cycles apart.

Source files
------------

// File: rtl/apb_seq_pkg.sv
// Shared definitions for the APB command sequencer: issuer FSM states and
// default interface sizes.
package apb_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } seq_state_e;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_CMD_DEPTH  = 4;
  localparam int DEF_RSP_DEPTH  = 4;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through head and occupancy count.
// DEPTH must be a power of two; the extra pointer bit separates full from empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/apb_cmd_sequencer.sv
// Queues host read/write commands, issues them one at a time to an APB master
// through a start/complete handshake, and returns responses in command order.
module apb_cmd_sequencer
  import apb_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CMD_DEPTH  = DEF_CMD_DEPTH,
  parameter int RSP_DEPTH  = DEF_RSP_DEPTH
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic                  cmd_write,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  rsp_write,
  output logic                  transfer_req,
  output logic [ADDR_WIDTH-1:0] transfer_addr,
  output logic [DATA_WIDTH-1:0] transfer_wdata,
  output logic                  transfer_write,
  input  logic                  transfer_ready,
  input  logic [DATA_WIDTH-1:0] transfer_rdata,
  input  logic                  transfer_error,
  output logic                  busy
);

  localparam int CMD_W = ADDR_WIDTH + DATA_WIDTH + 1;
  localparam int RSP_W = DATA_WIDTH + 2;
  localparam int CCW   = $clog2(CMD_DEPTH) + 1;
  localparam int RCW   = $clog2(RSP_DEPTH) + 1;
  localparam logic [RCW-1:0] RSP_SLOTS = RCW'(RSP_DEPTH);

  seq_state_e state, state_nxt;

  logic                  cmd_full, cmd_empty, cmd_push, cmd_pop;
  logic [CCW-1:0]        cmd_count;
  logic [CMD_W-1:0]      cmd_din, cmd_head;
  logic                  rsp_full, rsp_empty, rsp_push, rsp_pop;
  logic [RCW-1:0]        rsp_count;
  logic [RSP_W-1:0]      rsp_din, rsp_head;
  logic [DATA_WIDTH-1:0] rsp_rdata_in;
  logic                  issue;

  assign cmd_ready = presetn & ~cmd_full;
  assign cmd_push  = cmd_valid & cmd_ready;
  assign cmd_din   = {cmd_addr, cmd_wdata, cmd_write};

  // Nothing is outstanding in IDLE, so a free response slot now stays free
  // until this command's completion is pushed.
  assign issue   = (state == ST_IDLE) && !cmd_empty && (rsp_count < RSP_SLOTS);
  assign cmd_pop = issue;

  assign rsp_rdata_in = transfer_write ? '0 : transfer_rdata;
  assign rsp_din      = {rsp_rdata_in, transfer_error, transfer_write};
  assign rsp_push     = (state == ST_WAIT) && transfer_ready && !rsp_full;
  assign rsp_valid    = ~rsp_empty;
  assign rsp_pop      = rsp_valid & rsp_ready;
  assign rsp_rdata    = rsp_valid ? rsp_head[RSP_W-1:2] : '0;
  assign rsp_error    = rsp_valid & rsp_head[1];
  assign rsp_write    = rsp_valid & rsp_head[0];

  sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk   (pclk),
    .rst_n (presetn),
    .push  (cmd_push),
    .din   (cmd_din),
    .pop   (cmd_pop),
    .dout  (cmd_head),
    .full  (cmd_full),
    .empty (cmd_empty),
    .count (cmd_count)
  );

  sync_fifo #(.WIDTH(RSP_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk   (pclk),
    .rst_n (presetn),
    .push  (rsp_push),
    .din   (rsp_din),
    .pop   (rsp_pop),
    .dout  (rsp_head),
    .full  (rsp_full),
    .empty (rsp_empty),
    .count (rsp_count)
  );

  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (issue) state_nxt = ST_REQ;
      ST_REQ:  state_nxt = ST_WAIT;
      ST_WAIT: if (transfer_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state          <= ST_IDLE;
      transfer_addr  <= '0;
      transfer_wdata <= '0;
      transfer_write <= 1'b0;
    end else begin
      state <= state_nxt;
      if (issue) {transfer_addr, transfer_wdata, transfer_write} <= cmd_head;
    end
  end

  assign transfer_req = (state == ST_REQ);
  assign busy         = (state != ST_IDLE) || (cmd_count != '0);

endmodule
